// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl: scrolls FIFO-fed hex digits left across six 7-seg digits.
// Optional HEX_SCROLL_BLINK_EN: prescaler runs in IDLE and blinks the display.
module hex_scroll_ctrl #(
  parameter int TICK_DIV   = 25000000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_digit,
  input  logic        start,
  input  logic        stop,
  output logic [23:0] disp_digits,
  output logic [5:0]  disp_blank,
  output logic        busy,
  output logic        tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    DRAIN
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    drain, drain_n;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count, count_n;
  logic [23:0]   digits_n;
  logic [5:0]    blank, blank_n;
  logic          empty, go, shift, pop, push, run;
`ifdef HEX_SCROLL_BLINK_EN
  logic          phase, phase_n;
`endif

  always_comb begin
    empty    = (count == '0);
    go       = (state == IDLE) && start && !empty && !stop;
    shift    = (state != IDLE) && tick && !stop;
    pop      = shift && !empty;
    push     = wr_valid && wr_ready && !stop;
    state_n  = state;
    drain_n  = drain;
    digits_n = disp_digits;
    blank_n  = blank;
    if (shift) begin
      digits_n = {disp_digits[19:0], pop ? mem[rp] : 4'h0};
      blank_n  = {blank[4:0], !pop};
    end
    if (stop) begin
      state_n = IDLE;
      drain_n = '0;
    end else begin
      unique case (state)
        IDLE: if (go) state_n = SCROLL;
        SCROLL: begin
          if (shift && !pop) begin
            state_n = DRAIN;
            drain_n = 3'd1;
          end
        end
        DRAIN: begin
          if (pop) begin
            state_n = SCROLL;
            drain_n = '0;
          end else if (shift) begin
            // sixth blank shifted in: display fully blank
            if (drain == 3'd5) begin
              state_n = IDLE;
              drain_n = '0;
            end else begin
              drain_n = drain + 3'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
    count_n = count;
    if (stop) count_n = '0;
    else if (push && !pop) count_n = count + ONE;
    else if (pop && !push) count_n = count - ONE;
`ifdef HEX_SCROLL_BLINK_EN
    run = 1'b1;
    phase_n = phase;
    if (go) phase_n = 1'b0;
    else if (!stop && state == IDLE && tick) phase_n = !phase;
`else
    run = (state_n != IDLE);
`endif
    if (stop || go || !run || tick) cnt_n = '0;
    else cnt_n = cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wr_digit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      tick        <= 1'b0;
      drain       <= '0;
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      wr_ready    <= 1'b1;
      busy        <= 1'b0;
      disp_digits <= '0;
      blank       <= '1;
`ifdef HEX_SCROLL_BLINK_EN
      phase       <= 1'b0;
      disp_blank  <= '1;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      tick        <= (cnt_n == CMAX);
      drain       <= drain_n;
      count       <= count_n;
      wr_ready    <= (count_n != FULL);
      busy        <= (state_n != IDLE);
      disp_digits <= digits_n;
      blank       <= blank_n;
      if (stop) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push) wp <= wp + AW'(1);
        if (pop)  rp <= rp + AW'(1);
      end
`ifdef HEX_SCROLL_BLINK_EN
      phase       <= phase_n;
      disp_blank  <= blank_n | {6{phase_n}};
`endif
    end
  end

`ifndef HEX_SCROLL_BLINK_EN
  assign disp_blank = blank;
`endif

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// tb_hex_scroll_ctrl: directed + random stimulus against a queue/array model
// of the scroller, compared every cycle, plus hand-computed checkpoints.
module tb_hex_scroll_ctrl;

  localparam int TD = 4;
  localparam int FD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_valid = 1'b0;
  logic [3:0]  wr_digit = 4'h0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        wr_ready;
  logic [23:0] disp_digits;
  logic [5:0]  disp_blank;
  logic        busy;
  logic        tick;

  int tests = 0;
  int fails = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  hex_scroll_ctrl #(
    .TICK_DIV(TD),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_digit(wr_digit),
    .start(start),
    .stop(stop),
    .disp_digits(disp_digits),
    .disp_blank(disp_blank),
    .busy(busy),
    .tick(tick)
  );

  // model: digit queue, six display slots, mode 0=idle 1=scroll 2=drain
  int q[$];
  int md[6];
  bit mb[6];
  int mstate, mcnt, mdrain;
  bit mph;
  bit m_acc, m_t, m_has;

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 6; i++) begin
        md[i] = 0;
        mb[i] = 1'b1;
      end
      mstate = 0;
      mcnt = 0;
      mdrain = 0;
      mph = 1'b0;
    end else begin
      m_acc = wr_valid && (q.size() < FD);
      m_t = (mcnt == TD - 1);
      m_has = (q.size() > 0);
      if (stop) begin
        q.delete();
        mstate = 0;
        mcnt = 0;
        mdrain = 0;
      end else begin
        if (mstate == 0) begin
          if (start && m_has) begin
            mstate = 1;
            mcnt = 0;
            mph = 1'b0;
          end
`ifdef HEX_SCROLL_BLINK_EN
          else begin
            mcnt = (mcnt + 1) % TD;
            if (m_t) mph = !mph;
          end
`endif
        end else begin
          mcnt = (mcnt + 1) % TD;
          if (m_t) begin
            for (int i = 5; i > 0; i--) begin
              md[i] = md[i-1];
              mb[i] = mb[i-1];
            end
            if (m_has) begin
              md[0] = q.pop_front();
              mb[0] = 1'b0;
              mstate = 1;
              mdrain = 0;
            end else begin
              md[0] = 0;
              mb[0] = 1'b1;
              mdrain++;
              if (mdrain == 6) begin
                mstate = 0;
                mdrain = 0;
`ifndef HEX_SCROLL_BLINK_EN
                mcnt = 0;
`endif
              end else begin
                mstate = 2;
              end
            end
          end
        end
        if (m_acc) q.push_back(int'(wr_digit));
      end
    end
  end

  function automatic logic [23:0] exp_digits();
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*4 +: 4] = 4'(md[i]);
    return r;
  endfunction

  function automatic logic [5:0] exp_blank();
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i] = mb[i] | mph;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] d);
    wr_valid = 1'b1;
    wr_digit = d;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_digits"}, 32'(disp_digits), 32'h0);
    chk({nm, "_blank"}, 32'(disp_blank), 32'h3f);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
    chk({nm, "_tick"}, 32'(tick), 32'h0);
    chk({nm, "_ready"}, 32'(wr_ready), 32'h1);
  endtask

  initial begin
    fork
      begin
        while (!done) begin
          @(negedge clk);
          tests++;
          if (disp_digits !== exp_digits() || disp_blank !== exp_blank() ||
              busy !== (mstate != 0) || tick !== (mcnt == TD - 1) ||
              wr_ready !== (q.size() < FD)) begin
            fails++;
            $display("FAIL cycle_cmp t=%0t: digits %h/%h blank %b/%b busy %b/%b tick %b/%b ready %b/%b (got/required)",
                     $time, disp_digits, exp_digits(), disp_blank, exp_blank(),
                     busy, (mstate != 0), tick, (mcnt == TD - 1),
                     wr_ready, (q.size() < FD));
          end
        end
      end
      begin
        #1 rst_n = 1'b0;
        #1 chk_reset("por");
        cycles(2);
        #1 rst_n = 1'b1;

        push(4'h1);
        push(4'h2);
        push(4'h3);
        pulse_start();
        cycles(3);
        @(negedge clk);
        chk("first_tick", 32'(tick), 32'h1);
        cycles(9);
        @(negedge clk);
        chk("three_digits", 32'(disp_digits), 32'h000123);
        chk("three_blank", 32'(disp_blank), 32'h38);
        cycles(24);
        @(negedge clk);
        chk("drained_blank", 32'(disp_blank), 32'h3f);
        chk("drained_busy", 32'(busy), 32'h0);
        chk("drained_digits", 32'(disp_digits), 32'h0);

        for (int i = 0; i < 8; i++) push(4'(4 + i));
        @(negedge clk);
        chk("full_ready", 32'(wr_ready), 32'h0);
        wr_valid = 1'b1;
        wr_digit = 4'hf;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("ninth_ready", 32'(wr_ready), 32'h0);
        pulse_start();
        cycles(4);
        @(negedge clk);
        chk("pop_ready", 32'(wr_ready), 32'h1);
        chk("pop_digits", 32'(disp_digits), 32'h000004);
        chk("pop_blank", 32'(disp_blank), 32'h3e);
        cycles(41);
        @(negedge clk);
        push(4'hc);
        cycles(2);
        @(negedge clk);
        chk("drain_pop_digits", 32'(disp_digits), 32'hab000c);
        chk("drain_pop_blank", 32'(disp_blank), 32'h0e);
        chk("drain_pop_busy", 32'(busy), 32'h1);
        cycles(24);
        @(negedge clk);
        chk("redrain_busy", 32'(busy), 32'h0);
        chk("redrain_blank", 32'(disp_blank), 32'h3f);

        push(4'ha);
        push(4'hb);
        push(4'hc);
        pulse_start();
        cycles(5);
        #1 rst_n = 1'b0;
        #1 chk_reset("mid_rst");
        cycles(2);
        #1 rst_n = 1'b1;
        push(4'h7);
        push(4'h8);
        push(4'h9);
        pulse_start();
        cycles(4);
        @(negedge clk);
        chk("post_rst_digits", 32'(disp_digits), 32'h000007);
        chk("post_rst_blank", 32'(disp_blank), 32'h3e);
        @(posedge clk);
        #1;
        stop = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("stop_busy", 32'(busy), 32'h0);
        chk("stop_digits", 32'(disp_digits), 32'h000007);
        chk("stop_ready", 32'(wr_ready), 32'h1);
`ifdef HEX_SCROLL_BLINK_EN
        cycles(4);
        @(negedge clk);
        chk("blink_on", 32'(disp_blank), 32'h3f);
        cycles(4);
        @(negedge clk);
        chk("blink_off", 32'(disp_blank), 32'h3e);
`else
        chk("stop_blank", 32'(disp_blank), 32'h3e);
`endif
        cycles(10);
        @(negedge clk);
        chk("hold_digits", 32'(disp_digits), 32'h000007);
        pulse_start();
        @(negedge clk);
        chk("empty_start", 32'(busy), 32'h0);

        for (int n = 0; n < 3000; n++) begin
          wr_valid = ($urandom_range(0, 99) < 35);
          wr_digit = 4'($urandom);
          start = ($urandom_range(0, 99) < 6);
          stop = ($urandom_range(0, 199) == 0);
          rst_n = ($urandom_range(0, 1999) != 0);
          @(posedge clk);
          #1;
        end
        wr_valid = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        rst_n = 1'b1;
        cycles(2);
        done = 1'b1;
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hex_scroll_ctrl.md
HEX_SCROLL_CTRL -- requirements
Module: hex_scroll_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 25000000, meaning clocks per scroll tick (2 or more; 0.5 s at 50 MHz).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning input digit FIFO entries (power of 2, 2 or more).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port wr_valid, input, 1 bit: a digit is offered on wr_digit.
REQ-006 The block SHALL have port wr_ready, output, 1 bit: the FIFO can accept a digit.
REQ-007 The block SHALL have port wr_digit, input, 4 bits: hex digit 0x0-0xF.
REQ-008 The block SHALL have port start, input, 1 bit: single-cycle request to begin scrolling.
REQ-009 The block SHALL have port stop, input, 1 bit: single-cycle abort request.
REQ-010 The block SHALL have port disp_digits, output, 24 bits: {HEX5..HEX0} nibbles, each feeding one 7-segment decoder.
REQ-011 The block SHALL have port disp_blank, output, 6 bits: per-digit blank, 1 = decoder output forced to 7'b1111111.
REQ-012 The block SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-013 The block SHALL have port tick, output, 1 bit: one-cycle pulse on each prescaler wrap.

Function
REQ-014 A write SHALL be accepted on any clock edge where wr_valid and wr_ready are both high; wr_ready = !full, registered count based.
REQ-015 Push and pop in the same cycle SHALL leave the count unchanged; a pop SHALL occur only when the FIFO is non-empty (no bypass of an empty FIFO).
REQ-016 The prescaler SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be high for the cycle in which the count equals TICK_DIV-1.
REQ-017 The FSM SHALL have states IDLE, SCROLL and DRAIN.
REQ-018 IDLE: start with FIFO non-empty -> SCROLL with prescaler cleared to 0; start with FIFO empty SHALL be ignored.
REQ-019 SCROLL, on tick with FIFO non-empty: pop, shift left (HEXn <= HEXn-1, HEX0 <= popped digit, blank[0] <= 0, blank[n] <= blank[n-1]).
REQ-020 SCROLL, on tick with FIFO empty: -> DRAIN, shift in one blank digit, drain counter <= 1.
REQ-021 DRAIN, on tick with FIFO empty: shift in a blank digit and increment the drain counter; when the counter reaches 6 -> IDLE (display fully blank).
REQ-022 DRAIN, on tick with FIFO non-empty: pop and shift as in SCROLL, -> SCROLL, drain counter <= 0.
REQ-023 stop in any state SHALL -> IDLE next cycle, flush the FIFO and hold the displayed contents; stop SHALL take priority over start and tick in the same cycle.
REQ-024 Outside a shift, disp_digits and disp_blank SHALL hold their values; all outputs SHALL be registered.

Reset
REQ-025 With rst_n low, the block SHALL immediately force disp_digits=0, disp_blank=6'b111111, busy=0, tick=0, wr_ready=1, state IDLE, FIFO empty, prescaler=0 and drain counter=0.
REQ-026 Reset asserted mid-scroll SHALL discard all queued digits; operation SHALL resume on the first clock edge after rst_n rises.

Configuration
REQ-027 With macro HEX_SCROLL_BLINK_EN defined, the prescaler SHALL also run in IDLE, and in IDLE every tick SHALL toggle a blink phase that, while set, forces disp_blank to all ones; entering SCROLL SHALL clear the phase.
REQ-028 With HEX_SCROLL_BLINK_EN undefined, the prescaler SHALL be held at 0 in IDLE, tick SHALL not pulse in IDLE, and no blink logic SHALL exist.

Verification (TICK_DIV=4, FIFO_DEPTH=8)
REQ-029 Reset, then write 1,2,3 and pulse start -> ticks every 4 clocks; after the 3rd tick disp_digits=0x000123, disp_blank=6'b111000.
REQ-030 Continue with no further writes -> 6 drain ticks later disp_blank=6'b111111, state IDLE, busy=0.
REQ-031 Write 8 digits without start -> wr_ready=0 after the 8th; a 9th wr_valid is not accepted; after start and the first pop, wr_ready=1.
REQ-032 Write 1 digit during DRAIN at drain count 3 -> the next tick pops it into HEX0, state SCROLL, drain counter 0.
REQ-033 Assert stop and start in the same cycle during SCROLL -> IDLE, FIFO empty, display held; assert rst_n low mid-scroll -> all reset values appear immediately.
REQ-034 Build with HEX_SCROLL_BLINK_EN defined, idle with 0x000123 shown -> disp_blank alternates between 6'b111111 and 6'b111000 every 4 clocks.
